// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus result select/align driving the register-bank write port; outputs valid one rising edge after capture.
// Stall holds the register (bank rewrites the same value), flush loads a non-writing bubble, reset clears everything.
module wb_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rw,
    input  logic        mem_to_reg,
    input  logic        mem_link,
    input  logic [2:0]  mem_load_type,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_read_data,
    input  logic [31:0] mem_pc_plus8,
    output logic        reg_write,
    output logic [4:0]  rw,
    output logic [31:0] busw,
    output logic        wb_valid,
    output logic        align_error,
    output logic [31:0] retired
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic        r_valid;
    logic        r_reg_write;
    logic [4:0]  r_rw;
    logic        r_to_reg;
    logic        r_link;
    logic [2:0]  r_load_type;
    logic [31:0] r_alu_result;
    logic [31:0] r_read_data;
    logic [31:0] r_pc_plus8;
    logic [31:0] r_retired;

    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_misalign;

    // A flush only clears valid; the stale fields are harmless because every write path is gated by r_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rw         <= 5'd0;
            r_to_reg     <= 1'b0;
            r_link       <= 1'b0;
            r_load_type  <= 3'd0;
            r_alu_result <= 32'd0;
            r_read_data  <= 32'd0;
            r_pc_plus8   <= 32'd0;
            r_retired    <= 32'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid      <= mem_valid;
            r_reg_write  <= mem_reg_write;
            r_rw         <= mem_rw;
            r_to_reg     <= mem_to_reg;
            r_link       <= mem_link;
            r_load_type  <= mem_load_type;
            r_alu_result <= mem_alu_result;
            r_read_data  <= mem_read_data;
            r_pc_plus8   <= mem_pc_plus8;
            if (mem_valid) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign w_off = r_alu_result[1:0];

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte     = r_read_data[31:24];
        w_half     = w_off[1] ? r_read_data[15:0] : r_read_data[31:16];
        w_load     = r_read_data;
        w_misalign = 1'b0;
        case (w_off)
            2'd0: w_byte = r_read_data[31:24];
            2'd1: w_byte = r_read_data[23:16];
            2'd2: w_byte = r_read_data[15:8];
            2'd3: w_byte = r_read_data[7:0];
            default: w_byte = r_read_data[31:24];
        endcase
        case (r_load_type)
            LT_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            LT_LBU: w_load = {24'd0, w_byte};
            LT_LH: begin
                w_load     = {{16{w_half[15]}}, w_half};
                w_misalign = w_off[0];
            end
            LT_LHU: begin
                w_load     = {16'd0, w_half};
                w_misalign = w_off[0];
            end
            default: begin
                w_load     = r_read_data;
                w_misalign = (w_off != 2'd0);
            end
        endcase
    end

    assign align_error = r_valid & r_to_reg & ~r_link & w_misalign;
    assign busw        = r_link ? r_pc_plus8 : (r_to_reg ? w_load : r_alu_result);
    assign reg_write   = r_valid & r_reg_write & (r_rw != 5'd0) & ~align_error;
    assign rw          = r_rw;
    assign wb_valid    = r_valid;
    assign retired     = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected outputs are queued when stimulus is driven and compared after the capturing edge.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        mem_valid, mem_reg_write, mem_to_reg, mem_link;
    logic [4:0]  mem_rw;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus8;
    logic        reg_write, wb_valid, align_error;
    logic [4:0]  rw;
    logic [31:0] busw, retired;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        wb_valid;
        logic        align_error;
        logic [31:0] retired;
    } out_t;

    typedef struct {
        out_t  val;
        out_t  mask;
        string tag;
    } exp_t;

    localparam out_t ALL = '1;
    localparam out_t NO_DATA = '{reg_write: 1'b1, rw: 5'd0, busw: 32'd0, wb_valid: 1'b1,
                                 align_error: 1'b1, retired: 32'hFFFFFFFF};

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_ret  = 32'd0;

    wb_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rw(mem_rw),
        .mem_to_reg(mem_to_reg), .mem_link(mem_link), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_pc_plus8(mem_pc_plus8),
        .reg_write(reg_write), .rw(rw), .busw(busw), .wb_valid(wb_valid),
        .align_error(align_error), .retired(retired)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic drive(input logic v, input logic we, input logic [4:0] d, input logic tr,
                         input logic lk, input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc8);
        mem_valid = v; mem_reg_write = we; mem_rw = d; mem_to_reg = tr; mem_link = lk;
        mem_load_type = lt; mem_alu_result = alu; mem_read_data = rd; mem_pc_plus8 = pc8;
    endtask

    task automatic expect_out(input out_t v, input out_t m, input string tag);
        exp_t e;
        e.val = v; e.mask = m; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        out_t obs;
        reset = 1'b0; stall = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 5'd17, 1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_ret = 32'd0;
        expect_out('0, ALL, "reset");
        tick;
        obs = {reg_write, rw, busw, wb_valid, align_error, retired};
        e = exp_q.pop_front();
        n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
        else n_pass++;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_alu_write;
        exp_t e;
        out_t obs;
        drive(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0100);
        exp_ret = exp_ret + 1;
        expect_out('{1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, exp_ret}, ALL, "alu_write");
        tick;
        obs = {reg_write, rw, busw, wb_valid, align_error, retired};
        e = exp_q.pop_front();
        n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
        else n_pass++;
    endtask

    task automatic test_loads;
        logic [2:0]  lt[9]  = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3};
        logic [1:0]  off[9] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] want[9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h80FF_7F01,
                                 32'h0000_7F01};
        exp_t e;
        out_t obs;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, lt[i], {30'h400, off[i]}, 32'h80FF_7F01, 32'h0);
            exp_ret = exp_ret + 1;
            expect_out('{1'b1, 5'd7, want[i], 1'b1, 1'b0, exp_ret}, ALL, $sformatf("load%0d", i));
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_misalign;
        // lh off1, lw off2, reserved off1, lhu off3: error; then link over misaligned lw, and ALU result with low bits set
        logic [2:0]  lt[6]  = '{3'd3, 3'd0, 3'd7, 3'd4, 3'd0, 3'd0};
        logic [1:0]  off[6] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd3};
        logic        tr[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        lk[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        out_t obs;
        out_t v;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 5'd31, tr[i], lk[i], lt[i], {30'h2AA, off[i]}, 32'h80FF_7F01,
                  32'h0000_0408);
            exp_ret = exp_ret + 1;
            if (i < 4) begin
                v = '{1'b0, 5'd31, 32'd0, 1'b1, 1'b1, exp_ret};
                expect_out(v, NO_DATA | out_t'({1'b0, 5'h1F, 66'd0}), $sformatf("misalign%0d", i));
            end else begin
                v = '{1'b1, 5'd31, (i == 4) ? 32'h0000_0408 : {30'h2AA, off[i]}, 1'b1, 1'b0, exp_ret};
                expect_out(v, ALL, $sformatf("aligned_ok%0d", i));
            end
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_rw_zero;
        exp_t e;
        out_t obs;
        drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0);
        exp_ret = exp_ret + 1;
        expect_out('{1'b0, 5'd0, 32'h0BAD_F00D, 1'b1, 1'b0, exp_ret}, ALL, "rw_zero");
        tick;
        obs = {reg_write, rw, busw, wb_valid, align_error, retired};
        e = exp_q.pop_front();
        n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
        else n_pass++;
    endtask

    task automatic test_stall;
        exp_t e;
        out_t obs;
        out_t held;
        drive(1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0);
        exp_ret = exp_ret + 1;
        held = '{1'b1, 5'd9, 32'hAAAA_5555, 1'b1, 1'b0, exp_ret};
        expect_out(held, ALL, "pre_stall");
        for (int i = 0; i < 4; i++) begin
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
            stall = 1'b1;
            drive(1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 3'd1, 32'h1111_2222 + i, 32'h3, 32'h4);
            if (i < 3) expect_out(held, ALL, $sformatf("stall%0d", i));
        end
        stall = 1'b0;
    endtask

    task automatic test_stall_flush;
        exp_t e;
        out_t obs;
        logic st[3] = '{1'b1, 1'b0, 1'b1};
        logic fl[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            stall = st[i]; flush = fl[i];
            drive(1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 3'd0, 32'h7777_0000, 32'h0, 32'h0);
            expect_out('{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, exp_ret}, NO_DATA,
                       $sformatf("stall_flush%0d", i));
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_stalled;
        exp_t e;
        out_t obs;
        drive(1'b1, 1'b1, 5'd20, 1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        exp_ret = exp_ret + 1;
        expect_out('{1'b1, 5'd20, 32'hCAFE_0001, 1'b1, 1'b0, exp_ret}, ALL, "pre_reset");
        for (int i = 0; i < 2; i++) begin
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
            if (i == 0) begin
                stall = 1'b1; reset = 1'b0;
                exp_ret = 32'd0;
                expect_out('0, ALL, "reset_stalled");
            end
        end
        stall = 1'b0; reset = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic        v[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0]  d[5]  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        logic [31:0] a[5]  = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        exp_t e;
        out_t obs;
        for (int i = 0; i < 5; i++) begin
            drive(v[i], 1'b1, d[i], 1'b0, 1'b0, 3'd0, a[i], 32'h0, 32'h0);
            if (v[i]) exp_ret = exp_ret + 1;
            expect_out('{v[i], d[i], a[i], v[i], 1'b0, exp_ret}, ALL, $sformatf("b2b%0d", i));
            tick;
            obs = {reg_write, rw, busw, wb_valid, align_error, retired};
            e = exp_q.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        out_t obs;
        @(negedge clock);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        exp_ret = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 3'd0, 32'h0000_0042, 32'h0, 32'h0);
        exp_ret = exp_ret + 1;
        expect_out('{1'b1, 5'd8, 32'h0000_0042, 1'b1, 1'b0, exp_ret}, ALL, "wrap");
        tick;
        obs = {reg_write, rw, busw, wb_valid, align_error, retired};
        e = exp_q.pop_front();
        n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.tag, obs, e.val);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_alu_write;
        test_loads;
        test_misalign;
        test_rw_zero;
        test_stall;
        test_stall_flush;
        test_reset_stalled;
        test_back_to_back;
        test_wrap;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
